// File: rtl/fifo_rd_unpacker.sv
// Read-side unpacker: pulls RD_WIDTH words from the FIFO and streams OUT_WIDTH beats.
// Optional m_last output when FIFO_RD_UNPACKER_LAST_EN is defined.
module fifo_rd_unpacker #(
    parameter int RD_WIDTH  = 256,
    parameter int OUT_WIDTH = 32,
    parameter int MSB_FIRST = 1,
    localparam int RATIO    = RD_WIDTH / OUT_WIDTH,
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic [RD_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_valid,
    input  logic                 fifo_rd_rst_busy,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IDX_W-1:0]     beat_idx,
`ifdef FIFO_RD_UNPACKER_LAST_EN
    output logic                 m_last,
`endif
    output logic                 unexp_err
);

    typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

    word_t            active;
    word_t            pend;
    logic             occ_active;
    logic             occ_pend;
    logic             inflight;
    logic             rst_q;
    logic             err;
    logic [IDX_W-1:0] beat;
    logic [IDX_W-1:0] sel;
    logic [1:0]       used;
    logic             fire;
    logic             last_beat;
    logic             free_active;
    logic             take;
    logic             load_active;

    // Slots plus the outstanding read never exceed two words.
    assign used = 2'(occ_active) + 2'(occ_pend) + 2'(inflight);

    assign fifo_rd_en = !rst && !fifo_empty && !fifo_rd_rst_busy
                        && (used < 2'd2);

    assign fire        = occ_active && m_ready;
    assign last_beat   = (beat == IDX_W'(RATIO - 1));
    assign free_active = fire && last_beat;
    assign take        = fifo_valid && inflight;
    assign load_active = take
                         && (!occ_active || (free_active && !occ_pend));

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sel = IDX_W'(RATIO - 1) - beat;
        end else begin : g_lsb
            assign sel = beat;
        end
    endgenerate

    assign m_valid   = occ_active;
    assign m_data    = active[sel];
    assign beat_idx  = beat;
    assign unexp_err = err;

`ifdef FIFO_RD_UNPACKER_LAST_EN
    assign m_last = occ_active && last_beat;
`endif

    always_ff @(posedge rd_clk) begin
        rst_q <= rst;
        if (rst) begin
            occ_active <= 1'b0;
            occ_pend   <= 1'b0;
            inflight   <= 1'b0;
            beat       <= '0;
            err        <= 1'b0;
        end else begin
            inflight <= fifo_rd_en || (inflight && !fifo_valid);
            // A read issued just before reset may land right after it.
            if (fifo_valid && !inflight && !rst_q) begin
                err <= 1'b1;
            end
            if (fire) begin
                beat <= last_beat ? '0 : beat + IDX_W'(1);
            end
            if (free_active) begin
                occ_active <= occ_pend;
                occ_pend   <= 1'b0;
                if (occ_pend) begin
                    active <= pend;
                end
            end
            if (load_active) begin
                active     <= word_t'(fifo_dout);
                occ_active <= 1'b1;
            end else if (take) begin
                pend     <= word_t'(fifo_dout);
                occ_pend <= 1'b1;
            end
        end
    end

endmodule
